// File: rtl/rv_fabric_pkg.sv
`default_nettype none
// ============================================================================
// Module      : rv_fabric_pkg
// Description : Shared types and decode constants for the rv_mem_fabric
//               memory/IO fabric (FSM states, address regions, decode bits,
//               timeout fill value).
// Revision    : 1.0 - initial release
// ============================================================================
package rv_fabric_pkg;

  // Fabric access FSM states
  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_RAM  = 3'd1,
    ST_EXT  = 3'd2,
    ST_PER  = 3'd3,
    ST_DONE = 3'd4
  } state_t;

  // Target region of a CPU access
  typedef enum logic [1:0] {
    RG_RAM = 2'd0,
    RG_EXT = 2'd1,
    RG_PER = 2'd2
  } region_t;

  // Address decode bit positions
  localparam int REGION_BIT  = 31;
  localparam int EXT_PER_BIT = 16;
  localparam int CH_MSB      = 15;
  localparam int CH_LSB      = 12;

  // Read data returned by an external access that was aborted
  localparam logic [31:0] TIMEOUT_FILL = 32'hFFFF_FFFF;

  // Map a CPU byte address onto its target region
  function automatic region_t decode_region(input logic [31:0] addr);
    if (!addr[REGION_BIT]) begin
      return RG_RAM;
    end else if (!addr[EXT_PER_BIT]) begin
      return RG_EXT;
    end else begin
      return RG_PER;
    end
  endfunction

endpackage
`default_nettype wire

// File: rtl/rv_fabric_ram.sv
`default_nettype none
// ============================================================================
// Module      : rv_fabric_ram
// Description : Single-port 32-bit synchronous RAM with per-byte write
//               enables. Read data is registered and write-first, so a byte
//               written on an edge is visible on the output after that edge.
// Revision    : 1.0 - initial release
// ============================================================================
module rv_fabric_ram #(
  parameter int WORDS = 1024
) (
  input  logic                     clk,
  input  logic                     nrst,
  input  logic [$clog2(WORDS)-1:0] i_addr,
  input  logic [3:0]               i_we,
  input  logic [31:0]              i_wdata,
  output logic [31:0]              o_rdata
);

  logic [31:0] r_mem [WORDS];
  logic [31:0] r_rdata;

  // Byte-masked write into the storage array
  always_ff @(posedge clk) begin
    for (int b = 0; b < 4; b++) begin
      if (i_we[b]) begin
        r_mem[i_addr][8*b +: 8] <= i_wdata[8*b +: 8];
      end
    end
  end

  // Registered read port; written lanes forward the new byte
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_rdata <= '0;
    end else begin
      for (int b = 0; b < 4; b++) begin
        r_rdata[8*b +: 8] <= i_we[b] ? i_wdata[8*b +: 8] : r_mem[i_addr][8*b +: 8];
      end
    end
  end

  assign o_rdata = r_rdata;

endmodule
`default_nettype wire

// File: rtl/rv_mem_fabric.sv
`default_nettype none
// ============================================================================
// Module      : rv_mem_fabric
// Description : Registered-handshake memory/IO fabric between the PicoRV32
//               native memory port and internal RAM, external RAM and
//               peripheral channels, plus the byte-wide programming port
//               into internal RAM.
//               Optional feature macro: RV_FABRIC_TIMEOUT_EN (external
//               access timeout with abort to DONE and bus_err).
// Revision    : 1.0 - initial release
// ============================================================================
module rv_mem_fabric
  import rv_fabric_pkg::*;
#(
  parameter int MEM_WORDS      = 1024,
  parameter int EXT_WAIT       = 2,
  parameter int PERIPH_CH      = 2,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                   clk,
  input  logic                   nrst,
  input  logic                   cpu_valid,
  input  logic [31:0]            cpu_addr,
  input  logic [31:0]            cpu_wdata,
  input  logic [3:0]             cpu_wstrb,
  output logic                   cpu_ready,
  output logic [31:0]            cpu_rdata,
  input  logic                   prog_mode,
  input  logic [15:0]            prog_addr,
  input  logic [7:0]             prog_data,
  input  logic                   prog_low,
  input  logic                   prog_high,
  output logic [15:0]            prog_rdata,
  output logic [15:0]            ext_a,
  output logic [31:0]            ext_d_out,
  input  logic [31:0]            ext_d_in,
  output logic                   ext_cs,
  output logic                   ext_oe,
  output logic [3:0]             ext_wstrb,
  input  logic                   ext_rdy,
  output logic [5:0]             per_addr,
  output logic [7:0]             per_wdata,
  output logic [PERIPH_CH-1:0]   per_cs,
  output logic [PERIPH_CH-1:0]   per_oe,
  output logic [PERIPH_CH-1:0]   per_we,
  input  logic [8*PERIPH_CH-1:0] per_rdata,
  output logic                   bus_err
);

  // Word-address width of internal RAM (prog_addr covers up to 32K words)
  localparam int AW = $clog2(MEM_WORDS);

  state_t      r_state, w_next;
  region_t     r_region;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [3:0]  r_wstrb;
  logic [3:0]  r_ch;
  logic        r_ch_bad;
  logic [3:0]  r_wait;
  logic [31:0] r_rdata;
  logic        r_err;
  logic        r_prog_act;
  logic        r_prog_sel;

  logic          w_accept;
  region_t       w_region;
  logic [3:0]    w_ch;
  logic          w_ext_ok;
  logic          w_tmo_hit;
  logic          w_per_act;
  logic [7:0]    w_per_byte;
  logic [AW-1:0] w_ram_addr;
  logic [3:0]    w_ram_we;
  logic [31:0]   w_ram_wdata;
  logic [31:0]   w_ram_rdata;
  logic          w_unused;

  assign w_region = decode_region(cpu_addr);
  assign w_ch     = cpu_addr[CH_MSB:CH_LSB];
  assign w_accept = (r_state == ST_IDLE) && cpu_valid && !prog_mode;
  assign w_ext_ok = (r_wait == 4'd0) && ext_rdy;
  assign w_unused = ^{r_addr[31:16], prog_addr};

`ifdef RV_FABRIC_TIMEOUT_EN
  logic [15:0] r_tmo;

  // Count cycles spent in EXT so a stuck slave can be abandoned
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_tmo <= '0;
    end else if (r_state == ST_EXT) begin
      r_tmo <= r_tmo + 16'd1;
    end else begin
      r_tmo <= '0;
    end
  end

  assign w_tmo_hit = (r_tmo == 16'(TIMEOUT_CYCLES - 1));
`else
  logic w_unused_tmo;
  assign w_unused_tmo = (TIMEOUT_CYCLES == 0);
  assign w_tmo_hit    = 1'b0;
`endif

  // Internal RAM port: programmer owns it in prog_mode, otherwise the CPU
  always_comb begin
    w_ram_addr  = r_addr[AW+1:2];
    w_ram_we    = (r_state == ST_RAM) ? r_wstrb : 4'b0000;
    w_ram_wdata = r_wdata;
    if (prog_mode) begin
      w_ram_addr  = prog_addr[AW:1];
      w_ram_wdata = {4{prog_data}};
      if (prog_high) begin
        w_ram_we = prog_addr[0] ? 4'b1000 : 4'b0010;
      end else if (prog_low) begin
        w_ram_we = prog_addr[0] ? 4'b0100 : 4'b0001;
      end else begin
        w_ram_we = 4'b0000;
      end
    end
  end

  rv_fabric_ram #(
    .WORDS (MEM_WORDS)
  ) u_ram (
    .clk     (clk),
    .nrst    (nrst),
    .i_addr  (w_ram_addr),
    .i_we    (w_ram_we),
    .i_wdata (w_ram_wdata),
    .o_rdata (w_ram_rdata)
  );

  // Select the addressed peripheral channel's read byte
  always_comb begin
    w_per_byte = 8'h00;
    for (int n = 0; n < PERIPH_CH; n++) begin
      if (r_ch == 4'(n)) begin
        w_per_byte = per_rdata[8*n +: 8];
      end
    end
  end

  // Next-state decode and per-state strobes; prog_mode drops everything
  always_comb begin
    w_next    = r_state;
    cpu_ready = 1'b0;
    cpu_rdata = 32'h0;
    bus_err   = 1'b0;
    ext_cs    = 1'b0;
    ext_oe    = 1'b0;
    ext_wstrb = 4'b0000;
    ext_a     = 16'h0;
    ext_d_out = 32'h0;
    per_addr  = 6'h0;
    per_wdata = 8'h0;
    w_per_act = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          unique case (w_region)
            RG_RAM:  w_next = ST_RAM;
            RG_EXT:  w_next = ST_EXT;
            default: w_next = ST_PER;
          endcase
        end
      end
      ST_RAM: w_next = ST_DONE;
      ST_PER: begin
        w_next    = ST_DONE;
        w_per_act = !r_ch_bad;
        per_addr  = r_addr[7:2];
        per_wdata = r_wdata[7:0];
      end
      ST_EXT: begin
        ext_cs    = 1'b1;
        ext_oe    = (r_wstrb == 4'b0000);
        ext_wstrb = r_wstrb;
        ext_a     = r_addr[15:0];
        ext_d_out = r_wdata;
        if (w_ext_ok || w_tmo_hit) begin
          w_next = ST_DONE;
        end
      end
      ST_DONE: begin
        w_next    = ST_IDLE;
        cpu_ready = 1'b1;
        cpu_rdata = (r_region == RG_RAM) ? w_ram_rdata : r_rdata;
        bus_err   = r_err;
      end
      default: w_next = ST_IDLE;
    endcase
    if (prog_mode) begin
      w_next    = ST_IDLE;
      cpu_ready = 1'b0;
      cpu_rdata = 32'h0;
      bus_err   = 1'b0;
      ext_cs    = 1'b0;
      ext_oe    = 1'b0;
      ext_wstrb = 4'b0000;
      ext_a     = 16'h0;
      ext_d_out = 32'h0;
      per_addr  = 6'h0;
      per_wdata = 8'h0;
      w_per_act = 1'b0;
    end
  end

  // Per-channel strobes, live only in the single PER cycle
  for (genvar n = 0; n < PERIPH_CH; n++) begin : g_ch
    logic w_sel;
    assign w_sel     = w_per_act && (r_ch == 4'(n));
    assign per_cs[n] = w_sel;
    assign per_oe[n] = w_sel && (r_wstrb == 4'b0000);
    assign per_we[n] = w_sel && (r_wstrb != 4'b0000);
  end

  // FSM state register
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Request latch, wait counter and completion data/error capture
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_region <= RG_RAM;
      r_addr   <= '0;
      r_wdata  <= '0;
      r_wstrb  <= '0;
      r_ch     <= '0;
      r_ch_bad <= 1'b0;
      r_wait   <= '0;
      r_rdata  <= '0;
      r_err    <= 1'b0;
    end else begin
      if (w_accept) begin
        r_region <= w_region;
        r_addr   <= cpu_addr;
        r_wdata  <= cpu_wdata;
        r_wstrb  <= cpu_wstrb;
        r_ch     <= w_ch;
        r_ch_bad <= ({28'd0, w_ch} >= 32'(PERIPH_CH));
        r_wait   <= 4'(EXT_WAIT);
        r_rdata  <= '0;
        r_err    <= 1'b0;
      end
      if (r_state == ST_EXT && !prog_mode) begin
        if (r_wait != 4'd0) begin
          r_wait <= r_wait - 4'd1;
        end
        if (w_ext_ok) begin
          r_rdata <= ext_d_in;
          r_err   <= 1'b0;
        end else if (w_tmo_hit) begin
          r_rdata <= TIMEOUT_FILL;
          r_err   <= 1'b1;
        end
      end
      if (r_state == ST_PER && !prog_mode) begin
        r_rdata <= r_ch_bad ? 32'h0 : {24'h0, w_per_byte};
        r_err   <= r_ch_bad;
      end
    end
  end

  // Programmer read-back: remember which halfword the RAM output belongs to
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_prog_act <= 1'b0;
      r_prog_sel <= 1'b0;
    end else begin
      r_prog_act <= prog_mode;
      r_prog_sel <= prog_addr[0];
    end
  end

  assign prog_rdata = !r_prog_act ? 16'h0 :
                      (r_prog_sel ? w_ram_rdata[31:16] : w_ram_rdata[15:0]);

endmodule
`default_nettype wire

// File: tb/tb_rv_mem_fabric.sv
`default_nettype none
// ============================================================================
// Module      : tb_rv_mem_fabric
// Description : Directed self-checking bench for rv_mem_fabric
//               (EXT_WAIT=3, PERIPH_CH=2, TIMEOUT_CYCLES=8).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rv_mem_fabric;

  logic        clk = 1'b0;
  logic        nrst;
  logic        cpu_valid;
  logic [31:0] cpu_addr;
  logic [31:0] cpu_wdata;
  logic [3:0]  cpu_wstrb;
  logic        cpu_ready;
  logic [31:0] cpu_rdata;
  logic        prog_mode;
  logic [15:0] prog_addr;
  logic [7:0]  prog_data;
  logic        prog_low;
  logic        prog_high;
  logic [15:0] prog_rdata;
  logic [15:0] ext_a;
  logic [31:0] ext_d_out;
  logic [31:0] ext_d_in;
  logic        ext_cs;
  logic        ext_oe;
  logic [3:0]  ext_wstrb;
  logic        ext_rdy;
  logic [5:0]  per_addr;
  logic [7:0]  per_wdata;
  logic [1:0]  per_cs;
  logic [1:0]  per_oe;
  logic [1:0]  per_we;
  logic [15:0] per_rdata;
  logic        bus_err;

  rv_mem_fabric #(
    .MEM_WORDS      (1024),
    .EXT_WAIT       (3),
    .PERIPH_CH      (2),
    .TIMEOUT_CYCLES (8)
  ) dut (
    .clk        (clk),
    .nrst       (nrst),
    .cpu_valid  (cpu_valid),
    .cpu_addr   (cpu_addr),
    .cpu_wdata  (cpu_wdata),
    .cpu_wstrb  (cpu_wstrb),
    .cpu_ready  (cpu_ready),
    .cpu_rdata  (cpu_rdata),
    .prog_mode  (prog_mode),
    .prog_addr  (prog_addr),
    .prog_data  (prog_data),
    .prog_low   (prog_low),
    .prog_high  (prog_high),
    .prog_rdata (prog_rdata),
    .ext_a      (ext_a),
    .ext_d_out  (ext_d_out),
    .ext_d_in   (ext_d_in),
    .ext_cs     (ext_cs),
    .ext_oe     (ext_oe),
    .ext_wstrb  (ext_wstrb),
    .ext_rdy    (ext_rdy),
    .per_addr   (per_addr),
    .per_wdata  (per_wdata),
    .per_cs     (per_cs),
    .per_oe     (per_oe),
    .per_we     (per_we),
    .per_rdata  (per_rdata),
    .bus_err    (bus_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Per-access observations collected cycle by cycle
  int          ext_first, ext_last, oe_cnt, cs_cnt, we1_cnt, rdy_at;
  logic [5:0]  pa_we;
  logic [7:0]  pw_we;
  logic [15:0] ea_seen;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic sample(input int cyc);
    if (ext_cs) begin
      if (ext_first == 0) ext_first = cyc;
      ext_last = cyc;
      ea_seen  = ext_a;
    end
    if (ext_oe) oe_cnt++;
    if (|per_cs) cs_cnt++;
    if (per_we[1]) begin
      we1_cnt++;
      pa_we = per_addr;
      pw_we = per_wdata;
    end
    ext_rdy = (rdy_at == 0) || (cyc >= rdy_at);
  endtask

  // Issue one CPU request; lat is the cycle of cpu_ready (0 if none within max)
  task automatic cpu_req(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                         input int max, output int lat, output logic [31:0] rd,
                         output logic err);
    int cyc;
    ext_first = 0; ext_last = 0; oe_cnt = 0; cs_cnt = 0; we1_cnt = 0;
    pa_we = '0; pw_we = '0; ea_seen = '0;
    cpu_addr  = a;
    cpu_wdata = d;
    cpu_wstrb = s;
    cpu_valid = 1'b1;
    ext_rdy   = (rdy_at == 0);
    tick;
    cpu_valid = 1'b0;
    cyc = 1;
    sample(cyc);
    while (!cpu_ready && cyc < max) begin
      tick;
      cyc++;
      sample(cyc);
    end
    lat = cpu_ready ? cyc : 0;
    rd  = cpu_rdata;
    err = bus_err;
    if (cpu_ready) tick;
  endtask

  int          lat;
  logic [31:0] rd;
  logic        err;
  int          rdy_seen;

  initial begin
    nrst = 1'b0; cpu_valid = 1'b0; cpu_addr = '0; cpu_wdata = '0; cpu_wstrb = '0;
    prog_mode = 1'b0; prog_addr = '0; prog_data = '0; prog_low = 1'b0; prog_high = 1'b0;
    ext_d_in = 32'h1234_5678; ext_rdy = 1'b1; per_rdata = 16'h3C9A; rdy_at = 0;

    // Reset state
    #3;
    chk("rst_ready", {31'd0, cpu_ready}, 32'd0);
    chk("rst_rdata", cpu_rdata, 32'd0);
    chk("rst_strobes", {24'd0, ext_cs, ext_oe, per_cs, per_we, bus_err, 1'b0}, 32'd0);
    chk("rst_prog_rdata", {16'd0, prog_rdata}, 32'd0);
    repeat (2) @(posedge clk);
    #1 nrst = 1'b1;
    tick;

    // RAM: clear, byte-masked write, read back (and through an alias)
    cpu_req(32'h0000_0100, 32'h0, 4'b1111, 20, lat, rd, err);
    chk("ram_clr_lat", lat, 2);
    cpu_req(32'h0000_0100, 32'hDEAD_BEEF, 4'b0110, 20, lat, rd, err);
    chk("ram_wr_lat", lat, 2);
    cpu_req(32'h0000_0100, 32'h0, 4'b0000, 20, lat, rd, err);
    chk("ram_rd_lat", lat, 2);
    chk("ram_rd_data", rd, 32'h00AD_BE00);
    chk("ram_rd_err", {31'd0, err}, 32'd0);
    cpu_req(32'h7000_0100, 32'h0, 4'b0000, 20, lat, rd, err);
    chk("ram_alias_data", rd, 32'h00AD_BE00);

    // EXT read: 3 wait states plus 2 cycles of ext_rdy low
    rdy_at = 6;
    cpu_req(32'h8000_0040, 32'h0, 4'b0000, 50, lat, rd, err);
    rdy_at = 0;
    chk("ext_lat", lat, 7);
    chk("ext_rdata", rd, 32'h1234_5678);
    chk("ext_cs_first", ext_first, 1);
    chk("ext_cs_last", ext_last, 6);
    chk("ext_oe_cycles", oe_cnt, 6);
    chk("ext_a", {16'd0, ea_seen}, 32'h0040);

    // PER write to channel 1, then reads from both channels
    cpu_req(32'h8001_1004, 32'h0000_0055, 4'b0001, 20, lat, rd, err);
    chk("per_wr_lat", lat, 2);
    chk("per_we1_pulses", we1_cnt, 1);
    chk("per_addr", {26'd0, pa_we}, 32'd1);
    chk("per_wdata", {24'd0, pw_we}, 32'h55);
    chk("per_wr_err", {31'd0, err}, 32'd0);
    cpu_req(32'h8001_0008, 32'h0, 4'b0000, 20, lat, rd, err);
    chk("per_rd_ch0", rd, 32'h0000_009A);
    cpu_req(32'h8001_1000, 32'h0, 4'b0000, 20, lat, rd, err);
    chk("per_rd_ch1", rd, 32'h0000_003C);

    // Invalid channel: completes with zero data and bus_err
    cpu_req(32'h8001_F000, 32'h0, 4'b0000, 20, lat, rd, err);
    chk("bad_ch_lat", lat, 2);
    chk("bad_ch_rdata", rd, 32'h0);
    chk("bad_ch_err", {31'd0, err}, 32'd1);
    chk("bad_ch_cs", cs_cnt, 0);

    // Programming port
    prog_mode = 1'b1;
    prog_addr = 16'd2; prog_data = 8'h3C; prog_low = 1'b1;
    tick;
    prog_low = 1'b0;
    chk("prog_low_rb", {24'd0, prog_rdata[7:0]}, 32'h3C);
    prog_addr = 16'd3; prog_data = 8'hA5; prog_high = 1'b1; prog_low = 1'b1;
    tick;
    prog_high = 1'b0; prog_low = 1'b0;
    chk("prog_high_rb", {24'd0, prog_rdata[15:8]}, 32'hA5);
    prog_addr = 16'd2;
    #2;
    chk("prog_rb_hold", {24'd0, prog_rdata[15:8]}, 32'hA5);
    tick;
    chk("prog_rb_next", {24'd0, prog_rdata[7:0]}, 32'h3C);
    prog_mode = 1'b0;
    tick;
    cpu_req(32'h0000_0004, 32'h0, 4'b0000, 20, lat, rd, err);
    chk("prog_word_b3", {24'd0, rd[31:24]}, 32'hA5);
    chk("prog_word_b0", {24'd0, rd[7:0]}, 32'h3C);

    // prog_mode raised mid-EXT: back to IDLE, no cpu_ready
    ext_rdy = 1'b0;
    cpu_addr = 32'h8000_0010; cpu_wstrb = 4'b0000; cpu_valid = 1'b1;
    tick;
    cpu_valid = 1'b0;
    tick;
    chk("abort_ext_cs_before", {31'd0, ext_cs}, 32'd1);
    prog_mode = 1'b1;
    tick;
    prog_mode = 1'b0;
    ext_rdy = 1'b1;
    rdy_seen = 0;
    for (int i = 0; i < 20; i++) begin
      if (cpu_ready) rdy_seen++;
      tick;
    end
    chk("abort_no_ready", rdy_seen, 0);
    chk("abort_ext_cs_after", {31'd0, ext_cs}, 32'd0);

    // External timeout behaviour
    rdy_at = 1000000;
`ifdef RV_FABRIC_TIMEOUT_EN
    cpu_req(32'h8000_0020, 32'h0, 4'b0000, 50, lat, rd, err);
    chk("tmo_lat", lat, 9);
    chk("tmo_rdata", rd, 32'hFFFF_FFFF);
    chk("tmo_err", {31'd0, err}, 32'd1);
`else
    cpu_req(32'h8000_0020, 32'h0, 4'b0000, 1000, lat, rd, err);
    chk("no_tmo_ready", lat, 0);
    prog_mode = 1'b1;
    tick;
    prog_mode = 1'b0;
    tick;
`endif
    rdy_at = 0;
    ext_rdy = 1'b1;

    // Asynchronous reset in the middle of an EXT access
    ext_rdy = 1'b0;
    cpu_addr = 32'h8000_0030; cpu_wstrb = 4'b0000; cpu_valid = 1'b1;
    tick;
    cpu_valid = 1'b0;
    tick;
    #2 nrst = 1'b0;
    #1;
    chk("arst_ext_cs", {31'd0, ext_cs}, 32'd0);
    chk("arst_ext_oe", {31'd0, ext_oe}, 32'd0);
    chk("arst_ready", {31'd0, cpu_ready}, 32'd0);
    chk("arst_ext_a", {16'd0, ext_a}, 32'd0);
    ext_rdy = 1'b1;
    tick;
    nrst = 1'b1;
    tick;
    cpu_req(32'h0000_0100, 32'h0, 4'b0000, 20, lat, rd, err);
    chk("post_rst_lat", lat, 2);
    chk("post_rst_data", rd, 32'h00AD_BE00);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
